// File: rtl/snooze_countdown.sv
// BCD mm:ss snooze/countdown timer: loads a start value, counts down on tick_1s,
// pulses expired at 00:00 and rings until cancel, restart or ring timeout.
//   state    | meaning
//   S_IDLE   | stopped, waiting for a valid load
//   S_RUN    | counting down once per tick
//   S_PAUSED | count frozen, start resumes without reload
//   S_DONE   | reached 00:00, ring asserted
module snooze_countdown #(
  parameter int MIN_TENS_MAX = 9,
  parameter int RING_TIMEOUT = 60,
  parameter int RING_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_u,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic       ring,
  output logic       load_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  localparam logic [3:0]        L_MIN_T_MAX = 4'(MIN_TENS_MAX);
  localparam logic [RING_W-1:0] L_RING_TO   = RING_W'(RING_TIMEOUT);
  localparam logic [RING_W-1:0] L_RING_ONE  = RING_W'(1);

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt, w_dec, w_ld;
  logic [RING_W-1:0] r_ring_cnt, w_ring_cnt_nxt, w_ring_inc;
  logic              w_ld_ok, w_expired_nxt, w_load_err_nxt;
  logic              w_running_nxt, w_paused_nxt, w_ring_nxt;
  logic              r_running, r_paused, r_expired, r_ring, r_load_err;

  assign w_ld       = {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u};
  assign w_ring_inc = r_ring_cnt + L_RING_ONE;
  assign w_ld_ok    = (ld_min_t <= 4'd9) && (ld_min_t <= L_MIN_T_MAX) &&
                      (ld_min_u <= 4'd9) && (ld_sec_t <= 4'd5) &&
                      (ld_sec_u <= 4'd9) && (w_ld != 16'h0000);

  // one-second BCD borrow chain
  always_comb begin
    w_dec = r_cnt;
    if (r_cnt[3:0] != 4'd0) begin
      w_dec[3:0] = r_cnt[3:0] - 4'd1;
    end else begin
      w_dec[3:0] = 4'd9;
      if (r_cnt[7:4] != 4'd0) begin
        w_dec[7:4] = r_cnt[7:4] - 4'd1;
      end else begin
        w_dec[7:4] = 4'd5;
        if (r_cnt[11:8] != 4'd0) begin
          w_dec[11:8] = r_cnt[11:8] - 4'd1;
        end else begin
          w_dec[11:8]  = 4'd9;
          w_dec[15:12] = r_cnt[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'h0000;
      r_ring_cnt <= '0;
      r_running  <= 1'b0;
      r_paused   <= 1'b0;
      r_expired  <= 1'b0;
      r_ring     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_running  <= w_running_nxt;
      r_paused   <= w_paused_nxt;
      r_expired  <= w_expired_nxt;
      r_ring     <= w_ring_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  // only the highest-priority active input acts: cancel > start > pause > tick
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ring_cnt_nxt = r_ring_cnt;
    w_expired_nxt  = 1'b0;
    w_load_err_nxt = 1'b0;
    if (cancel) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = 16'h0000;
      w_ring_cnt_nxt = '0;
    end else if (start) begin
      if (r_state == S_PAUSED) begin
        w_state_nxt = S_RUN;
      end else if (w_ld_ok) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = w_ld;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (pause) begin
      if (r_state == S_RUN) w_state_nxt = S_PAUSED;
    end else if (tick_1s) begin
      case (r_state)
        S_RUN: begin
          w_cnt_nxt = w_dec;
          if (w_dec == 16'h0000) begin
            w_state_nxt    = S_DONE;
            w_expired_nxt  = 1'b1;
            w_ring_cnt_nxt = '0;
          end
        end
        S_DONE: begin
          w_ring_cnt_nxt = w_ring_inc;
          if ((L_RING_TO != '0) && (w_ring_inc == L_RING_TO)) w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_running_nxt = (w_state_nxt == S_RUN);
    w_paused_nxt  = (w_state_nxt == S_PAUSED);
    w_ring_nxt    = (w_state_nxt == S_DONE);
  end

  assign min_t    = r_cnt[15:12];
  assign min_u    = r_cnt[11:8];
  assign sec_t    = r_cnt[7:4];
  assign sec_u    = r_cnt[3:0];
  assign running  = r_running;
  assign paused   = r_paused;
  assign expired  = r_expired;
  assign ring     = r_ring;
  assign load_err = r_load_err;

endmodule
